// File: rtl/jt51_wrq.sv
// Host-side write queue for the JT51 register file: buffers (addr, data) pairs and replays them as
// address/data strobes, respecting busy. Optional macro JT51_WRQ_SKIPADDR_EN skips redundant address strobes.
module jt51_wrq #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP        = 2
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_addr,
  input  logic [7:0]            req_data,
  output logic [7:0]            mmr_din,
  output logic                  mmr_write,
  output logic                  mmr_a0,
  input  logic                  mmr_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE       = (DEPTH_LOG2+1)'(1);
  localparam logic [3:0]          HOLD_LAST = 4'(GAP - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, HOLD, WBUSY} state_t;

  state_t                  state;
  logic [15:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     level_nxt;
  logic                    push, pop, skip;
  logic [7:0]              pop_addr, pop_data;
  logic [7:0]              cur_addr, cur_data;
  logic [3:0]              hold_cnt;

  // Pop only from a registered non-empty level, push only when not full; flush overrides both.
  assign push = req_valid & req_ready & ~flush;
  assign pop  = (state == IDLE) & (level != '0) & ~flush;
  assign {pop_addr, pop_data} = mem[rd_ptr];
  assign idle = (state == IDLE) & (level == '0);

  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (push & ~pop)
      level_nxt = level + ONE;
    else if (pop & ~push)
      level_nxt = level - ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {req_addr, req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      req_ready <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      level     <= level_nxt;
      req_ready <= (level_nxt != FULL);
    end
  end

`ifdef JT51_WRQ_SKIPADDR_EN
  logic [7:0] last_addr;
  logic       last_valid;

  // The register file keeps the selected address latched, so a repeat address needs no strobe.
  assign skip = last_valid & (pop_addr == last_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= 1'b0;
    end else begin
      if (state == DATA) last_valid <= 1'b1;
      if (flush)         last_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA) last_addr <= cur_addr;
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (pop) begin
      cur_addr <= pop_addr;
      cur_data <= pop_data;
    end
  end

  // Strobe outputs are registered: they are set on the transition into ADDR/DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mmr_write <= 1'b0;
      mmr_a0    <= 1'b0;
      mmr_din   <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            mmr_write <= 1'b1;
            if (skip) begin
              mmr_a0  <= 1'b1;
              mmr_din <= pop_data;
              state   <= DATA;
            end else begin
              mmr_a0  <= 1'b0;
              mmr_din <= pop_addr;
              state   <= ADDR;
            end
          end
        end
        ADDR: begin
          mmr_write <= 1'b0;
          state     <= GAP1;
        end
        GAP1: begin
          mmr_write <= 1'b1;
          mmr_a0    <= 1'b1;
          mmr_din   <= cur_data;
          state     <= DATA;
        end
        DATA: begin
          mmr_write <= 1'b0;
          hold_cnt  <= HOLD_LAST;
          state     <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0)
            state <= WBUSY;
          else
            hold_cnt <= hold_cnt - 1'b1;
        end
        WBUSY: begin
          if (!mmr_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_wrq.sv
// Scoreboard bench for jt51_wrq: expected strobes are queued at push time and matched as they appear.
module tb_jt51_wrq;
  localparam int DL  = 4;
  localparam int GAP = 2;

  logic          rst, clk, flush, req_valid, req_ready;
  logic [7:0]    req_addr, req_data, mmr_din;
  logic          mmr_write, mmr_a0, mmr_busy, idle;
  logic [DL:0]   level;

  int n_chk, n_pass, cyc, strobe_cnt, addr_cyc, data_cyc, push_cyc;
  logic [8:0] exp_q[$];
  logic [7:0] m_last;
  bit         m_lv;

  jt51_wrq #(.DEPTH_LOG2(DL), .GAP(GAP)) dut (
    .rst(rst), .clk(clk), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .mmr_din(mmr_din), .mmr_write(mmr_write),
    .mmr_a0(mmr_a0), .mmr_busy(mmr_busy), .level(level), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Strobe monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && mmr_write) begin
      strobe_cnt++;
      if (mmr_a0) data_cyc = cyc;
      else        addr_cyc = cyc;
      check("strobe_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("strobe", {mmr_a0, mmr_din}, exp_q.pop_front());
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic expect_write(logic [7:0] a, logic [7:0] d);
    bit skip = 1'b0;
`ifdef JT51_WRQ_SKIPADDR_EN
    skip = m_lv && (m_last == a);
`endif
    if (!skip) exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b1, d});
    m_last = a;
    m_lv   = 1'b1;
  endtask

  task automatic push_wr(logic [7:0] a, logic [7:0] d);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d;
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    if (!req_ready) check("push_timeout", 32'(req_ready), 1);
    else begin
      @(posedge clk); #1;
      push_cyc = cyc;
      expect_write(a, d);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_data(int d0);
    int t = 0;
    while (data_cyc == d0 && t < 300) begin tick(1); t++; end
    check("data_strobe_seen", 32'(data_cyc != d0), 1);
  endtask

  task automatic wait_idle(string tag);
    int t = 0;
    do begin tick(1); t++; end while (!idle && t < 400);
    check(tag, 32'(idle), 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, s0, r, a0c, t;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; mmr_busy = 1'b0;
    m_lv = 1'b0; m_last = '0;
    repeat (3) @(negedge clk);
    check("rst_write", 32'(mmr_write), 0);
    check("rst_a0",    32'(mmr_a0), 0);
    check("rst_din",   32'(mmr_din), 0);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_level", 32'(level), 0);
    check("rst_idle",  32'(idle), 1);
    rst = 1'b0;
    tick(2);

    // Single write and its strobe timing.
    push_wr(8'h20, 8'hC7);
    wait_idle("single_idle");
    check("addr_latency", addr_cyc - push_cyc, 1);
    check("addr_to_data", data_cyc - addr_cyc, 2);

    // Fill: hold the FSM in WBUSY, queue 16 entries, then one more must wait for a pop.
    mmr_busy = 1'b1;
    d0 = data_cyc;
    push_wr(8'h30, 8'h00);
    wait_data(d0);
    for (int i = 0; i < 16; i++) push_wr(8'h40 + 8'(i), 8'(i * 3 + 1));
    check("full_level", 32'(level), 16);
    check("full_ready", 32'(req_ready), 0);
    fork
      push_wr(8'h50, 8'h55);
      begin
        s0 = strobe_cnt;
        tick(6);
        check("held_level", 32'(level), 16);
        check("held_ready", 32'(req_ready), 0);
        check("held_no_strobe", strobe_cnt, s0);
        mmr_busy = 1'b0;
      end
    join
    wait_idle("fill_idle");

    // Long busy after a data strobe.
    d0 = data_cyc;
    push_wr(8'h60, 8'h11);
    push_wr(8'h61, 8'h22);
    wait_data(d0);
    mmr_busy = 1'b1;
    s0 = strobe_cnt;
    tick(40);
    check("busy_no_strobe", strobe_cnt, s0);
    mmr_busy = 1'b0;
    r = cyc; a0c = addr_cyc; t = 0;
    while (addr_cyc == a0c && t < 50) begin tick(1); t++; end
    check("busy_release", 32'((addr_cyc > r) && (addr_cyc - r <= 2)), 1);
    wait_idle("busy_idle");

    // Repeated address.
    s0 = strobe_cnt;
    push_wr(8'h08, 8'h01);
    push_wr(8'h08, 8'h79);
    wait_idle("skip_idle");
`ifdef JT51_WRQ_SKIPADDR_EN
    check("skip_strobes", strobe_cnt - s0, 3);
`else
    check("skip_strobes", strobe_cnt - s0, 4);
`endif

    // Flush during HOLD with five entries queued.
    mmr_busy = 1'b1;
    push_wr(8'h70, 8'hA0);
    for (int i = 1; i <= 6; i++) push_wr(8'h70 + 8'(i), 8'hA0 + 8'(i));
    d0 = data_cyc;
    mmr_busy = 1'b0;
    wait_data(d0);
    mmr_busy = 1'b1;
    tick(1);
    check("flush_pre_level", 32'(level), 5);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    exp_q.delete();
    m_lv = 1'b0;
    check("flush_level", 32'(level), 0);
    check("flush_ready", 32'(req_ready), 1);
    s0 = strobe_cnt;
    mmr_busy = 1'b0;
    tick(30);
    check("flush_no_strobe", strobe_cnt, s0);
    check("flush_idle", 32'(idle), 1);

    // Reset in the middle of a strobe.
    push_wr(8'h80, 8'h5A);
    t = 0;
    while (!mmr_write && t < 20) begin tick(1); t++; end
    check("rst_strobe_seen", 32'(mmr_write), 1);
    rst = 1'b1;
    #1;
    check("arst_write", 32'(mmr_write), 0);
    check("arst_level", 32'(level), 0);
    check("arst_ready", 32'(req_ready), 1);
    check("arst_idle",  32'(idle), 1);
    exp_q.delete();
    m_lv = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    push_wr(8'h90, 8'h33);
    wait_idle("post_rst_idle");

    check("final_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
